// File: rtl/avalon_arb_pkg.sv
// Shared state encoding and constants for the two-master Avalon-MM arbiter.
package avalon_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    ERR  = 2'd3
  } arb_state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  function automatic logic [1:0] grant_onehot(input logic owner);
    return owner ? GRANT_M1 : GRANT_M0;
  endfunction

endpackage

// File: rtl/avalon_arb_watchdog.sv
// Counts consecutive stalled cycles of a granted transfer and flags the cycle
// in which the count reaches TIMEOUT.
module avalon_arb_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic stall_i,
  output logic tc_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: cnt_d is given a default before any branch so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (stall_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = stall_i & (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/avalon_mm_arbiter.sv
// Two-master, one-slave Avalon-MM arbiter with a stall watchdog.
// Define AVALON_ARB_ROUND_ROBIN_EN for round-robin; otherwise m0 has fixed priority.
module avalon_mm_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int unsigned   DW       = 32,
  parameter int unsigned   AW       = 32,
  parameter int unsigned   TIMEOUT  = 64,
  parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEFAULT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] m0_address,
  input  logic          m0_read,
  input  logic          m0_write,
  input  logic          m0_chipselect,
  input  logic [DW-1:0] m0_writedata,
  output logic          m0_waitrequest,
  output logic [DW-1:0] m0_readdata,
  input  logic [AW-1:0] m1_address,
  input  logic          m1_read,
  input  logic          m1_write,
  input  logic          m1_chipselect,
  input  logic [DW-1:0] m1_writedata,
  output logic          m1_waitrequest,
  output logic [DW-1:0] m1_readdata,
  output logic [AW-1:0] s_address,
  output logic          s_read,
  output logic          s_write,
  output logic          s_chipselect,
  output logic [DW-1:0] s_writedata,
  input  logic          s_waitrequest,
  input  logic [DW-1:0] s_readdata,
  output logic [1:0]    grant,
  output logic [1:0]    err
);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_grant_q, last_grant_d;
  logic [1:0] err_q, err_d;
  logic       m0_req, m1_req, cur_req, granted, pick_m1, wd_tc;

  assign m0_req  = m0_chipselect & (m0_read | m0_write);
  assign m1_req  = m1_chipselect & (m1_read | m1_write);
  assign granted = (state_q == GNT0) || (state_q == GNT1);
  assign cur_req = (state_q == GNT1) ? m1_req : m0_req;

`ifdef AVALON_ARB_ROUND_ROBIN_EN
  // Under contention, serve the master that was not served last.
  assign pick_m1 = (m0_req & m1_req) ? ~last_grant_q : m1_req;
`else
  logic unused_last_grant;
  assign pick_m1           = ~m0_req;
  assign unused_last_grant = last_grant_q;
`endif

  avalon_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear_i(~granted),
    .stall_i(granted & s_waitrequest),
    .tc_o   (wd_tc)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    unique case (state_q)
      IDLE: begin
        if (m0_req | m1_req) begin
          owner_d = pick_m1;
          state_d = pick_m1 ? GNT1 : GNT0;
        end
      end
      GNT0, GNT1: begin
        // A withdrawn request drops back to IDLE without counting as served.
        if (!cur_req) begin
          state_d = IDLE;
        end else if (!s_waitrequest) begin
          state_d      = IDLE;
          last_grant_d = owner_q;
        end else if (wd_tc) begin
          state_d = ERR;
        end
      end
      ERR: begin
        err_d[owner_q] = 1'b1;
        last_grant_d   = owner_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_chipselect   = 1'b0;
    s_writedata    = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_readdata    = '0;
    grant          = GRANT_NONE;
    unique case (state_q)
      GNT0: begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_chipselect   = m0_chipselect;
        s_writedata    = m0_writedata;
        m0_waitrequest = s_waitrequest;
        m0_readdata    = s_readdata;
        grant          = GRANT_M0;
      end
      GNT1: begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_chipselect   = m1_chipselect;
        s_writedata    = m1_writedata;
        m1_waitrequest = s_waitrequest;
        m1_readdata    = s_readdata;
        grant          = GRANT_M1;
      end
      ERR: begin
        // Slave strobes stay low here, so an aborted write never lands.
        grant = grant_onehot(owner_q);
        if (owner_q) begin
          m1_waitrequest = 1'b0;
          m1_readdata    = ERR_DATA;
        end else begin
          m0_waitrequest = 1'b0;
          m0_readdata    = ERR_DATA;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      err_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Self-checking bench: a cycle model of the arbitration rules plus directed transfers.
`timescale 1ns/1ps
module tb_avalon_mm_arbiter;

  localparam int          TIMEOUT  = 8;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset;

  logic [1:0]       mrd, mwr, mcs, mwait;
  logic [1:0][31:0] ma, mwd, mrdata;
  logic [31:0]      s_address, s_writedata, s_readdata;
  logic             s_read, s_write, s_chipselect, s_waitrequest;
  logic [1:0]       grant, err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  avalon_mm_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .reset         (reset),
    .m0_address    (ma[0]),
    .m0_read       (mrd[0]),
    .m0_write      (mwr[0]),
    .m0_chipselect (mcs[0]),
    .m0_writedata  (mwd[0]),
    .m0_waitrequest(mwait[0]),
    .m0_readdata   (mrdata[0]),
    .m1_address    (ma[1]),
    .m1_read       (mrd[1]),
    .m1_write      (mwr[1]),
    .m1_chipselect (mcs[1]),
    .m1_writedata  (mwd[1]),
    .m1_waitrequest(mwait[1]),
    .m1_readdata   (mrdata[1]),
    .s_address     (s_address),
    .s_read        (s_read),
    .s_write       (s_write),
    .s_chipselect  (s_chipselect),
    .s_writedata   (s_writedata),
    .s_waitrequest (s_waitrequest),
    .s_readdata    (s_readdata),
    .grant         (grant),
    .err           (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave: memory with a programmable number of wait cycles, or a permanent stall.
  logic [31:0] mem [256];
  int          scnt  = 0;
  int          swait = 0;
  bit          hang  = 1'b0;

  initial for (int i = 0; i < 256; i++) mem[i] = i;

  always_comb s_waitrequest = hang || (scnt < swait);
  always_comb s_readdata    = mem[s_address[7:0]];

  always @(posedge clk) begin
    if (s_chipselect && (s_read || s_write)) begin
      if (!s_waitrequest) begin
        if (s_write) mem[s_address[7:0]] <= s_writedata;
        scnt <= 0;
      end else begin
        scnt <= scnt + 1;
      end
    end else begin
      scnt <= 0;
    end
  end

  // Reference model: which master owns the bus, whether it is in its abort
  // cycle, how long it has stalled, who was served last, sticky errors.
  int         m_owner  = -1;
  bit         m_errph  = 1'b0;
  int         m_stalls = 0;
  int         m_last   = 1;
  logic [1:0] m_err    = 2'b00;
  bit         started  = 1'b0;

  always @(negedge clk) begin
    logic [1:0]       req, e_grant, e_wait;
    logic [1:0][31:0] e_rd;
    logic             e_srd, e_swr, e_scs;
    logic [31:0]      e_sa, e_swd;
    req = mcs & (mrd | mwr);
    if (started) begin
      e_grant = 2'b00; e_wait = 2'b11; e_rd = '0;
      e_srd = 1'b0; e_swr = 1'b0; e_scs = 1'b0; e_sa = '0; e_swd = '0;
      if (m_owner >= 0) begin
        e_grant[m_owner] = 1'b1;
        if (m_errph) begin
          e_wait[m_owner] = 1'b0;
          e_rd[m_owner]   = ERR_WORD;
        end else begin
          e_srd = mrd[m_owner]; e_swr = mwr[m_owner]; e_scs = mcs[m_owner];
          e_sa  = ma[m_owner];  e_swd = mwd[m_owner];
          e_wait[m_owner] = s_waitrequest;
          e_rd[m_owner]   = s_readdata;
        end
      end
      check("mdl_grant", grant, e_grant);
      check("mdl_err", err, m_err);
      check("mdl_waitrequest", mwait, e_wait);
      check("mdl_readdata0", mrdata[0], e_rd[0]);
      check("mdl_readdata1", mrdata[1], e_rd[1]);
      check("mdl_s_strobes", {s_chipselect, s_read, s_write}, {e_scs, e_srd, e_swr});
      check("mdl_s_address", s_address, e_sa);
      check("mdl_s_writedata", s_writedata, e_swd);
    end
    if (reset) begin
      m_owner = -1; m_errph = 1'b0; m_stalls = 0; m_last = 1; m_err = 2'b00;
      started = 1'b1;
    end else if (m_errph) begin
      m_err[m_owner] = 1'b1;
      m_last  = m_owner;
      m_errph = 1'b0;
      m_owner = -1;
    end else if (m_owner < 0) begin
      if (req != 2'b00) begin
`ifdef AVALON_ARB_ROUND_ROBIN_EN
        m_owner = (req == 2'b11) ? 1 - m_last : (req[1] ? 1 : 0);
`else
        m_owner = req[0] ? 0 : 1;
`endif
        m_stalls = 0;
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
    end else if (!s_waitrequest) begin
      m_last  = m_owner;
      m_owner = -1;
    end else begin
      m_stalls++;
      if (m_stalls == TIMEOUT) m_errph = 1'b1;
    end
  end

  // Record each new grant that follows an idle cycle.
  logic [1:0] gq[$];
  logic [1:0] prev_grant = 2'b00;
  always @(negedge clk) begin
    if (grant != 2'b00 && prev_grant == 2'b00) gq.push_back(grant);
    prev_grant <= grant;
  end

  // Present a transfer on master m and wait for its waitrequest to drop.
  // Returns the number of cycles from presentation to completion.
  task automatic do_xfer(input int m, input bit wr, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rdata);
    int start;
    bit done;
    @(posedge clk); #1;
    mcs[m] = 1'b1; mrd[m] = !wr; mwr[m] = wr; ma[m] = a; mwd[m] = d;
    start = cyc; done = 1'b0; lat = -1; rdata = '0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (mwait[m] == 1'b0) begin
        done  = 1'b1;
        lat   = cyc - start;
        rdata = mrdata[m];
      end
    end
    if (!done) check("xfer_completes", 1'b0, 1'b1);
  endtask

  task automatic release_m(input int m);
    @(posedge clk); #1;
    mcs[m] = 1'b0; mrd[m] = 1'b0; mwr[m] = 1'b0; ma[m] = '0; mwd[m] = '0;
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "global timeout");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic [1:0]  exp_seq [5];
    reset = 1'b1;
    mcs = '0; mrd = '0; mwr = '0; ma = '0; mwd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_grant", grant, 2'b00);
    check("reset_err", err, 2'b00);
    check("reset_waitrequest", mwait, 2'b11);
    check("reset_s_strobes", {s_chipselect, s_read, s_write}, 3'b000);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single read, zero-wait slave.
    do_xfer(0, 1'b0, 32'd5, 32'd0, lat, rd);
    check("zw_latency", lat, 1);
    check("zw_readdata", rd, 32'd5);
    release_m(0);
    swait = 2;
    @(negedge clk);
    check("zw_wait_one_cycle", mwait[0], 1'b1);
    check("zw_back_to_idle", grant, 2'b00);

    // Write then read back through a 2-wait slave.
    do_xfer(1, 1'b1, 32'd10, 32'h1234_5678, lat, rd);
    check("w2_write_latency", lat, 3);
    do_xfer(1, 1'b0, 32'd10, 32'd0, lat, rd);
    check("w2_read_latency", lat, 3);
    check("w2_readback", rd, 32'h1234_5678);
    release_m(1);
    swait = 0;
    gq.delete();

    // Both masters request back-to-back for four transfers each.
    fork
      begin
        int          l0;
        logic [31:0] r0;
        for (int i = 0; i < 4; i++) do_xfer(0, 1'b0, 32'd20 + i, 32'd0, l0, r0);
        release_m(0);
      end
      begin
        int          l1;
        logic [31:0] r1;
        for (int i = 0; i < 4; i++) do_xfer(1, 1'b0, 32'd40 + i, 32'd0, l1, r1);
        release_m(1);
      end
    join
`ifdef AVALON_ARB_ROUND_ROBIN_EN
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`else
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
`endif
    for (int i = 0; i < 5; i++)
      check($sformatf("contend_grant%0d", i), (i < gq.size()) ? gq[i] : 2'b11, exp_seq[i]);

    // Timeout: slave never releases waitrequest.
    @(posedge clk); #1;
    hang = 1'b1;
    do_xfer(0, 1'b0, 32'd3, 32'd0, lat, rd);
    check("to_latency", lat, TIMEOUT + 1);
    check("to_readdata", rd, ERR_WORD);
    release_m(0);
    hang = 1'b0;
    @(negedge clk);
    check("to_idle_grant", grant, 2'b00);
    check("to_err_set", err, 2'b01);
    do_xfer(0, 1'b0, 32'd7, 32'd0, lat, rd);
    check("after_to_readdata", rd, 32'd7);
    release_m(0);
    swait = 3;
    @(negedge clk);
    check("to_err_sticky", err, 2'b01);

    // Reset while m1 is granted and stalled.
    @(posedge clk); #1;
    mcs[1] = 1'b1; mrd[1] = 1'b1; ma[1] = 32'd9;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_pre_grant", grant, 2'b10);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mcs[1] = 1'b0; mrd[1] = 1'b0; ma[1] = '0;
    swait = 0;
    @(negedge clk);
    check("rst_grant", grant, 2'b00);
    check("rst_s_strobes", {s_read, s_write}, 2'b00);
    check("rst_waitrequest", mwait, 2'b11);
    check("rst_err", err, 2'b00);
    check("rst_s_address", s_address, 32'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avalon_mm_arbiter.md
# avalon_mm_arbiter

Two-master, one-slave Avalon-MM arbiter that shares a single `avalon_mm_slave` memory between two requesters, such as a bus-functional master and a DMA engine. It grants one master at a time and passes that master's transfer through to the slave. Each master is held off with `waitrequest` until its transfer completes. A watchdog aborts any transfer the slave stalls indefinitely, so the bus cannot lock up.

## Interface
Parameters:
- `DW`, 32, data width
- `AW`, 32, address width
- `TIMEOUT`, 64, max consecutive granted cycles with `s_waitrequest` high; must be ≥1
- `ERR_DATA`, 32'hDEAD_BEEF, readdata returned on timeout

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high
- `m0_address`/`m1_address`  in  AW  master address
- `m0_read`/`m1_read`, `m0_write`/`m1_write`, `m0_chipselect`/`m1_chipselect`  in  1  master strobes
- `m0_writedata`/`m1_writedata`  in  DW  master write data
- `m0_waitrequest`/`m1_waitrequest`  out  1  hold-off to master
- `m0_readdata`/`m1_readdata`  out  DW  read data to master
- `s_address` out AW, `s_read`/`s_write`/`s_chipselect` out 1, `s_writedata` out DW  slave side
- `s_waitrequest` in 1, `s_readdata` in DW  slave responses
- `grant`  out  2  one-hot current grant, 00 when idle
- `err`  out  2  sticky per-master timeout flag

## Operation
- Request: `mX_req = mX_chipselect & (mX_read | mX_write)`.
- FSM states are IDLE, GNT0, GNT1 and ERR.
- **IDLE**:
  - All slave strobes are 0.
  - Both `mX_waitrequest` are 1.
  - On any request, the next state is GNT0 or GNT1 per the arbitration rule.
- **GNTx**:
  - The `s_*` outputs combinationally mirror master x.
  - `mX_waitrequest = s_waitrequest`.
  - `mX_readdata = s_readdata`.
  - The other master's `waitrequest` is 1.
- **Completion**: a cycle in GNTx with `mX_req=1` and `s_waitrequest=0`. The next state is IDLE and `last_grant ← x`.
- **Request withdrawn** while in GNTx (protocol violation): the next state is IDLE. No completion is signalled and `last_grant` is unchanged.
- **Timeout**:
  - The watchdog counts granted cycles with `s_waitrequest=1` and clears on entry to GNTx.
  - When the count reaches TIMEOUT, the next state is ERR.
- **ERR**, one cycle:
  - Slave strobes are 0.
  - Master x sees `waitrequest=0` and `readdata=ERR_DATA`; a write is discarded.
  - `err[x] ← 1`, `last_grant ← x`.
  - The next state is IDLE.
- **Idle outputs**: `mX_readdata` is `s_readdata` when granted and 0 otherwise. `s_address`/`s_writedata` are 0 when IDLE.
- **Reset**: taken from any state, mid-transfer included. Next cycle:
  - state IDLE, `grant=00`, `err=00`, `last_grant=1`, watchdog 0
  - `mX_waitrequest=1`, all slave strobes 0, all data/address outputs 0

## Timing
- A request is presented at cycle N in IDLE. The grant registers at N+1 and the slave sees strobes from N+1.
- Zero-wait slave: completion at N+1, master waitrequest low for exactly cycle N+1, IDLE at N+2.
- Sustained throughput is one transfer per 2 cycles per port. The IDLE gap cycle is mandatory and gives the other master a chance to arbitrate.
- Slave with W wait cycles: completion at N+1+W.
- Timeout: ERR at N+1+TIMEOUT, IDLE at N+2+TIMEOUT.
- A request that arrives while the other master is granted waits; the earliest grant is the cycle after IDLE.

## Configuration
- Macro: `AVALON_ARB_ROUND_ROBIN_EN`.
- **Defined**: when both request in IDLE, grant the master ≠ `last_grant`. After reset this means m0 first. A single requester is always granted.
- **Undefined**: fixed priority, m0 always wins a simultaneous request. `last_grant` is still maintained but unused.

## Structure
- Package `avalon_arb_pkg`: state enum (IDLE/GNT0/GNT1/ERR), `ERR_DATA` default, grant encoding constants.
- Sub-module `avalon_arb_watchdog`: `$clog2(TIMEOUT+1)`-bit counter with inputs `clear`/`stall` and a terminal-count output, instantiated once.

## Test plan
- **Single read, zero-wait slave**: m0 reads address 5. Require `m0_readdata=5` at N+1 and `m0_waitrequest` low for exactly 1 cycle.
- **Write then read, 2-wait slave**: m1 writes 32'h1234_5678 to address 10, then reads it back. Require completion at N+3 and readback 32'h1234_5678.
- **Simultaneous requests, macro defined**: both masters request continuously for 4 transfers. Require `grant` sequence 01,10,01,10.
- **Simultaneous requests, macro undefined**: both masters request continuously for 4 transfers. Require m0 is granted every time until it drops its request.
- **Timeout**: hold `s_waitrequest=1` with TIMEOUT=8 while m0 reads. Require ERR at N+9, `m0_readdata=32'hDEAD_BEEF`, `err=01` sticky, IDLE at N+10.
- **Reset mid-transfer**: assert `reset` during GNT1. Require next cycle `grant=00`, `s_read=s_write=0`, both waitrequests 1, `err=00`.
